// File: rtl/color_pkg.sv
// Shared definitions for the colour channel sequencer: filter-select codes,
// channel indices, FSM state encoding and channel-search helpers.
package color_pkg;

    // S2/S3 codes driven to the sensor, {s2, s3}
    localparam logic [1:0] FILT_RED   = 2'b00;
    localparam logic [1:0] FILT_GREEN = 2'b11;
    localparam logic [1:0] FILT_BLUE  = 2'b01;
    localparam logic [1:0] FILT_CLEAR = 2'b10;

    // Channel indices, also the scan order and the SCAN_MASK bit positions
    localparam logic [1:0] CH_R = 2'd0;
    localparam logic [1:0] CH_G = 2'd1;
    localparam logic [1:0] CH_B = 2'd2;
    localparam logic [1:0] CH_C = 2'd3;

    localparam int NUM_CH = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_COUNT   = 3'd2,
        ST_STORE   = 3'd3,
        ST_PUBLISH = 3'd4
    } state_t;

    // Filter-select code for a channel index
    function automatic logic [1:0] filt_code(input logic [1:0] ch);
        logic [1:0] code;
        case (ch)
            CH_R:    code = FILT_RED;
            CH_G:    code = FILT_GREEN;
            CH_B:    code = FILT_BLUE;
            default: code = FILT_CLEAR;
        endcase
        return code;
    endfunction

    // Lowest enabled channel at or above 'start'; returns {found, index}
    function automatic logic [2:0] find_ch(input logic [3:0] mask, input logic [2:0] start);
        logic [2:0] hit;
        hit = 3'b000;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if ((i >= int'(start)) && mask[i]) begin
                hit = {1'b1, 2'(i)};
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser for the asynchronous sensor output followed by a
// rising-edge detector. pulse is high for one clk when the synchronised
// level goes 0 -> 1.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic meta;
    logic sync;
    logic prev;

    // Synchroniser chain plus one delayed copy for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign pulse = sync & ~prev;

endmodule

// File: rtl/color_channel_sequencer.sv
// Colour channel sequencer: steps the sensor filter through the enabled
// channels, counts synchronised rising edges of freq_in over a gate window
// per channel, and publishes one coherent set of counts per frame.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | sensor disabled, waiting for run
//   ST_SETTLE  | filter just changed, edges ignored for SETTLE_CYCLES
//   ST_COUNT   | gate open for GATE_CYCLES, edges counted (saturating)
//   ST_STORE   | counter copied to the channel shadow, pick next channel
//   ST_PUBLISH | shadows copied to outputs, frame_valid pulsed next cycle
module color_channel_sequencer
    import color_pkg::*;
#(
    parameter int         GATE_CYCLES   = 100000,
    parameter int         SETTLE_CYCLES = 1000,
    parameter int         CNT_W         = 16,
    parameter logic [3:0] SCAN_MASK     = 4'b1111
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             freq_in,
    output logic             s2,
    output logic             s3,
    output logic             sensor_oe_n,
    output logic [CNT_W-1:0] red_cnt,
    output logic [CNT_W-1:0] green_cnt,
    output logic [CNT_W-1:0] blue_cnt,
    output logic [CNT_W-1:0] clear_cnt,
    output logic             frame_valid,
    output logic             sat
);

    localparam int TMAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    // Timer counts down from N-1 to 0, so a state lasts exactly N cycles
    localparam logic [TW-1:0]    GATE_LD   = TW'(GATE_CYCLES - 1);
    localparam logic [TW-1:0]    SETTLE_LD = TW'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [2:0]       FIRST_HIT = find_ch(SCAN_MASK, 3'd0);

    state_t           state;
    state_t           state_nxt;
    logic [TW-1:0]    tmr;
    logic             tmr_tc;
    logic [1:0]       ch;
    logic [2:0]       nxt_hit;
    logic             edge_pulse;
    logic [CNT_W-1:0] acc;
    logic             sat_frame;
    logic [CNT_W-1:0] shadow [NUM_CH];

    logic             load_settle;
    logic             load_gate;
    logic             sel_en;
    logic [1:0]       sel_ch;
    logic             oe_off;
    logic             do_store;
    logic             do_publish;

    edge_sync u_edge_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (freq_in),
        .pulse (edge_pulse)
    );

    assign tmr_tc  = (tmr == '0);
    assign nxt_hit = find_ch(SCAN_MASK, {1'b0, ch} + 3'd1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-state control strobes
    always_comb begin
        state_nxt   = state;
        load_settle = 1'b0;
        load_gate   = 1'b0;
        sel_en      = 1'b0;
        sel_ch      = ch;
        oe_off      = 1'b0;
        do_store    = 1'b0;
        do_publish  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run && FIRST_HIT[2]) begin
                    state_nxt   = ST_SETTLE;
                    load_settle = 1'b1;
                    sel_en      = 1'b1;
                    sel_ch      = FIRST_HIT[1:0];
                end
            end
            ST_SETTLE: begin
                if (tmr_tc) begin
                    state_nxt = ST_COUNT;
                    load_gate = 1'b1;
                end
            end
            ST_COUNT: begin
                if (tmr_tc) begin
                    state_nxt = ST_STORE;
                end
            end
            ST_STORE: begin
                do_store = 1'b1;
                if (nxt_hit[2]) begin
                    state_nxt   = ST_SETTLE;
                    load_settle = 1'b1;
                    sel_en      = 1'b1;
                    sel_ch      = nxt_hit[1:0];
                end else begin
                    state_nxt = ST_PUBLISH;
                end
            end
            ST_PUBLISH: begin
                do_publish = 1'b1;
                if (run) begin
                    state_nxt   = ST_SETTLE;
                    load_settle = 1'b1;
                    sel_en      = 1'b1;
                    sel_ch      = FIRST_HIT[1:0];
                end else begin
                    state_nxt = ST_IDLE;
                    oe_off    = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                oe_off    = 1'b1;
            end
        endcase
    end

    // Settle/gate down-counter, reloaded on every state entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr <= '0;
        end else if (load_settle) begin
            tmr <= SETTLE_LD;
        end else if (load_gate) begin
            tmr <= GATE_LD;
        end else if (!tmr_tc) begin
            tmr <= tmr - 1'b1;
        end
    end

    // Channel select, filter pins and sensor enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch          <= CH_R;
            s2          <= 1'b0;
            s3          <= 1'b0;
            sensor_oe_n <= 1'b1;
        end else if (sel_en) begin
            ch          <= sel_ch;
            {s2, s3}    <= filt_code(sel_ch);
            sensor_oe_n <= 1'b0;
        end else if (oe_off) begin
            sensor_oe_n <= 1'b1;
        end
    end

    // Saturating edge counter; sat_frame remembers any overflow attempt this frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            sat_frame <= 1'b0;
        end else begin
            if (load_gate) begin
                acc <= '0;
            end else if ((state == ST_COUNT) && edge_pulse) begin
                if (acc == CNT_MAX) begin
                    sat_frame <= 1'b1;
                end else begin
                    acc <= acc + 1'b1;
                end
            end
            if (do_publish) begin
                sat_frame <= 1'b0;
            end
        end
    end

    // Per-channel shadow registers; masked channels are never written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= '0;
            end
        end else if (do_store) begin
            shadow[ch] <= acc;
        end
    end

    // Output registers change only on publish, together with the valid pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red_cnt     <= '0;
            green_cnt   <= '0;
            blue_cnt    <= '0;
            clear_cnt   <= '0;
            sat         <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= do_publish;
            if (do_publish) begin
                red_cnt   <= shadow[CH_R];
                green_cnt <= shadow[CH_G];
                blue_cnt  <= shadow[CH_B];
                clear_cnt <= shadow[CH_C];
                sat       <= sat_frame;
            end
        end
    end

endmodule
